// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: memory-stage request/response bundle between pipeline and data memory
interface data_mem_responder_if;
    logic        memrq;
    logic        memwq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        misaligned;
    modport master (
        output memrq, memwq, addr, wdata, funct3,
        input  rdata, rvalid, stall, misaligned
    );
    modport slave (
        input  memrq, memwq, addr, wdata, funct3,
        output rdata, rvalid, stall, misaligned
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated word RAM servicing RV32I loads/stores; DMEM_MISALIGN_TRAP_EN enables misalignment trapping
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [AW+1:0] addr_q, e_addr;
    logic [31:0]   wdata_q, wd_rep, word, sh, ld_val;
    logic [2:0]    f3_q, e_f3;
    logic          wr_q, e_wr, e_mis, mis_q, req, unused_addr;
    logic [1:0]    e_lane, lane_q;
    logic [3:0]    be;
    logic [31:0]   mem [DEPTH_WORDS];

    assign req         = bus.memrq | bus.memwq;
    assign unused_addr = ^bus.addr[31:AW+2];
    assign bus.stall   = !rst && (state == IDLE ? req : state == WAIT);

    // next-state and wait counter
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n = 4'd0;
                if (req) state_n = (WC == 4'd0) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_n = cnt + 4'd1;
                if (cnt + 4'd1 == WC) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // effective access: live inputs while idle (zero-wait path), latched copy afterwards; load data extraction
    always_comb begin
        e_addr = (state == IDLE) ? bus.addr[AW+1:0] : addr_q;
        e_f3   = (state == IDLE) ? bus.funct3 : f3_q;
        e_wr   = (state == IDLE) ? bus.memwq : wr_q;
        e_lane = e_f3[1:0] == 2'b01 ? {e_addr[1], 1'b0} : e_f3[1:0] == 2'b10 ? 2'b00 : e_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        e_mis  = (e_f3[1:0] == 2'b01 && e_addr[0]) || (e_f3[1:0] == 2'b10 && e_addr[1:0] != 2'b00);
`else
        e_mis  = 1'b0;
`endif
        word   = mem[e_addr[AW+1:2]];
        sh     = word >> {e_lane, 3'b000};
        ld_val = e_mis ? 32'd0 :
                 e_f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                 e_f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                 e_f3 == 3'b010 ? sh :
                 e_f3 == 3'b100 ? {24'd0, sh[7:0]} :
                 e_f3 == 3'b101 ? {16'd0, sh[15:0]} : 32'd0;
    end

    // store byte enables and lane-replicated write data for the DONE cycle
    always_comb begin
        be     = mis_q ? 4'b0000 :
                 f3_q == 3'b000 ? 4'b0001 << lane_q :
                 f3_q == 3'b001 ? (lane_q[1] ? 4'b1100 : 4'b0011) :
                 f3_q == 3'b010 ? 4'b1111 : 4'b0000;
        wd_rep = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                 f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    end

    // FSM state, request capture and registered load response
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.rdata      <= 32'd0;
            bus.rvalid     <= 1'b0;
            bus.misaligned <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bus.rvalid     <= state_n == DONE && !e_wr;
            bus.misaligned <= state_n == DONE && e_mis;
            if (state == IDLE && req) begin
                addr_q  <= bus.addr[AW+1:0];
                wdata_q <= bus.wdata;
                f3_q    <= bus.funct3;
                wr_q    <= bus.memwq;
            end
            if (state_n == DONE) begin
                lane_q <= e_lane;
                mis_q  <= e_mis;
            end
            if (state_n == DONE && !e_wr) bus.rdata <= ld_val;
        end
    end

    // RAM write at the end of DONE; suppressed by reset
    always_ff @(posedge clk) begin
        if (!rst && state == DONE && wr_q)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wd_rep[8*b +: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: vector table plus reset corner sequences with an rvalid scoreboard
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus();
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {logic [31:0] d; logic m;} exp_t;
    typedef struct {logic rq; logic wr; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; logic [31:0] d; logic m;} vec_t;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t e_mon;
    logic [31:0] last_rd = 32'd0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // every load completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.rvalid === 1'b1) begin
            if (sb.size() == 0) chk("spurious_rvalid", 32'd1, 32'd0);
            else begin
                e_mon = sb.pop_front();
                chk("sb_rdata", bus.rdata, e_mon.d);
                chk("sb_misaligned", {31'd0, bus.misaligned}, {31'd0, e_mon.m});
            end
        end
    end

    task automatic access(input logic rq, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] d, input logic m, input string nm);
        int n = 0;
        @(negedge clk);
        bus.memrq = rq; bus.memwq = wr; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        if (rq && !wr) sb.push_back('{d, m});
        #1 chk({nm, "_stall_idle"}, {31'd0, bus.stall}, 32'd1);
        do begin
            @(posedge clk); #1; n++;
        end while (bus.stall && n < 20);
        chk({nm, "_latency"}, n, 32'd2);
        chk({nm, "_rvalid"}, {31'd0, bus.rvalid}, {31'd0, rq && !wr});
        chk({nm, "_misaligned"}, {31'd0, bus.misaligned}, {31'd0, m});
        if (rq && !wr) last_rd = d;
        else if (!m) chk({nm, "_rdata_hold"}, bus.rdata, last_rd);
        @(negedge clk);
        bus.memrq = 1'b0; bus.memwq = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{0, 1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h10,  32'h0, 32'hDEADBEEF, 0});
        vecs.push_back('{0, 1, 3'd2, 32'h20,  32'h0, 32'h0, 0});
        vecs.push_back('{0, 1, 3'd0, 32'h21,  32'h80, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd0, 32'h21,  32'h0, 32'hFFFFFF80, 0});
        vecs.push_back('{1, 0, 3'd4, 32'h21,  32'h0, 32'h00000080, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h20,  32'h0, 32'h00008000, 0});
        vecs.push_back('{1, 0, 3'd1, 32'h20,  32'h0, 32'hFFFF8000, 0});
        vecs.push_back('{1, 0, 3'd5, 32'h22,  32'h0, 32'h0, 0});
        vecs.push_back('{0, 1, 3'd2, 32'h24,  32'h11223344, 32'h0, 0});
        vecs.push_back('{0, 1, 3'd1, 32'h26,  32'h0000ABCD, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h24,  32'h0, 32'hABCD3344, 0});
        vecs.push_back('{1, 0, 3'd0, 32'h27,  32'h0, 32'hFFFFFFAB, 0});
        vecs.push_back('{1, 0, 3'd4, 32'h24,  32'h0, 32'h00000044, 0});
        vecs.push_back('{1, 0, 3'd3, 32'h24,  32'h0, 32'h0, 0});
        vecs.push_back('{0, 1, 3'd3, 32'h24,  32'hFFFFFFFF, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h24,  32'h0, 32'hABCD3344, 0});
        vecs.push_back('{1, 1, 3'd2, 32'h30,  32'h5, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h30,  32'h0, 32'h5, 0});
        vecs.push_back('{0, 1, 3'd2, 32'h400, 32'hA5, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h000, 32'h0, 32'hA5, 0});
        vecs.push_back('{0, 1, 3'd2, 32'h40,  32'h12345678, 32'h0, 0});
        vecs.push_back('{1, 0, 3'd2, 32'h42,  32'h0, TRAP ? 32'h0 : 32'h12345678, TRAP});
        vecs.push_back('{1, 0, 3'd5, 32'h43,  32'h0, TRAP ? 32'h0 : 32'h00001234, TRAP});
        vecs.push_back('{0, 1, 3'd2, 32'h41,  32'hCAFEF00D, 32'h0, TRAP});
        vecs.push_back('{1, 0, 3'd2, 32'h40,  32'h0, TRAP ? 32'h12345678 : 32'hCAFEF00D, 0});

        bus.memrq = 1'b1; bus.memwq = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.funct3 = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);
        chk("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_misaligned", {31'd0, bus.misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.memrq = 1'b0;

        foreach (vecs[i])
            access(vecs[i].rq, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].d, vecs[i].m, $sformatf("v%0d", i));

        access(0, 1, 3'd2, 32'h40, 32'h1, 32'h0, 0, "pre40");
        @(negedge clk);
        bus.memwq = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h40; bus.wdata = 32'h7;
        @(posedge clk); #1;
        chk("rst_wait_stall_before", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1; bus.memwq = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait_stall_after", {31'd0, bus.stall}, 32'd0);
        chk("rst_wait_rvalid", {31'd0, bus.rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'd0;
        access(1, 0, 3'd2, 32'h40, 32'h0, 32'h1, 0, "rst_wait_lw");

        access(0, 1, 3'd2, 32'h44, 32'h2, 32'h0, 0, "pre44");
        @(negedge clk);
        bus.memwq = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h44; bus.wdata = 32'h9;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_done_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1; bus.memwq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'd0;
        access(1, 0, 3'd2, 32'h44, 32'h0, 32'h2, 0, "rst_done_lw");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
